// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold-time limit.
// Ports: clk, reset (async, active-low), req[7:0] in;
//        grant[7:0], grant_id[2:0], busy, timeout, ptr[7:0] out.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] ptr
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  hold;
  logic [7:0]  hold_n;
  logic [7:0]  grant_n;
  logic [2:0]  gid_n;
  logic        busy_n;
  logic        timeout_n;
  logic [7:0]  ptr_n;
  logic [7:0]  pick;
  logic [2:0]  pick_id;
  logic [2:0]  ptr_id;
  logic        found;
  logic        expire;

  function automatic logic [2:0] enc8(
    input logic [7:0] v
  );
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = r | 3'(i);
    end
    return r;
  endfunction

  assign ptr_id  = enc8(ptr);
  assign pick_id = enc8(pick);
  assign expire  = (hold == 8'(HOLD_MAX - 1));

  // Scan upward from the pointer, wrapping 7 -> 0;
  // 3-bit index arithmetic provides the wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[ptr_id + 3'(i)]) begin
        pick[ptr_id + 3'(i)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    hold_n    = hold;
    grant_n   = grant;
    gid_n     = grant_id;
    timeout_n = 1'b0;
    ptr_n     = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          grant_n = pick;
          gid_n   = pick_id;
          hold_n  = '0;
        end
      end
      GRANT: begin
        // Holder drop wins over expiry: no timeout.
        if (!req[grant_id] || expire) begin
          state_n   = IDLE;
          grant_n   = '0;
          gid_n     = '0;
          hold_n    = '0;
          timeout_n = req[grant_id];
          ptr_n     = {grant[6:0], grant[7]};
        end else begin
          hold_n = hold + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == GRANT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold     <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 8'b0000_0001;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      grant    <= grant_n;
      grant_id <= gid_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
      ptr      <= ptr_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of rr_arbiter8.
// Runs with HOLD_MAX = 4 so expiry is reachable.
module tb_rr_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;
  logic [7:0] ptr;

  int total = 0;
  int bad   = 0;

  rr_arbiter8 #(
    .HOLD_MAX(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .grant_id(grant_id),
    .busy    (busy),
    .timeout (timeout),
    .ptr     (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] g,
    input logic [2:0] id,
    input logic [7:0] p,
    input logic       to
  );
    logic b;
    b = (g != 8'd0);
    total++;
    assert (grant === g && grant_id === id &&
            busy === b && timeout === to &&
            ptr === p)
    else begin
      bad++;
      $error("FAIL %s got g=%b id=%0d b=%b to=%b p=%b exp g=%b id=%0d b=%b to=%b p=%b",
             tag, grant, grant_id, busy, timeout, ptr,
             g, id, b, to, p);
    end
  endtask

  initial begin
    reset = 1'b0;
    req   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 8'h00, 3'd0, 8'h01, 1'b0);
    reset = 1'b1;

    // single requester, held three cycles
    req = 8'b0000_0100;
    tick(); chk("s1_c1", 8'h04, 3'd2, 8'h01, 1'b0);
    tick(); chk("s1_c2", 8'h04, 3'd2, 8'h01, 1'b0);
    tick(); chk("s1_c3", 8'h04, 3'd2, 8'h01, 1'b0);
    req = 8'd0;
    tick(); chk("s1_rel", 8'h00, 3'd0, 8'h08, 1'b0);
    tick(); chk("s1_idle", 8'h00, 3'd0, 8'h08, 1'b0);

    // move ptr to bit 6, then wrap the scan
    req = 8'b0010_0000;
    tick(); chk("s2_g5", 8'h20, 3'd5, 8'h08, 1'b0);
    req = 8'd0;
    tick(); chk("s2_rel", 8'h00, 3'd0, 8'h40, 1'b0);
    req = 8'b0000_0011;
    tick(); chk("s2_wrap", 8'h01, 3'd0, 8'h40, 1'b0);
    req = 8'd0;
    tick(); chk("s2_rel2", 8'h00, 3'd0, 8'h02, 1'b0);

    // return ptr to bit 0
    req = 8'b1000_0000;
    tick(); chk("s3_g7", 8'h80, 3'd7, 8'h02, 1'b0);
    req = 8'd0;
    tick(); chk("s3_rel", 8'h00, 3'd0, 8'h01, 1'b0);

    // alternate bit 1 and bit 7
    req = 8'b1000_0010;
    tick(); chk("s3_a1", 8'h02, 3'd1, 8'h01, 1'b0);
    tick(); chk("s3_a2", 8'h02, 3'd1, 8'h01, 1'b0);
    req = 8'b1000_0000;
    tick(); chk("s3_dead1", 8'h00, 3'd0, 8'h04, 1'b0);
    req = 8'b1000_0010;
    tick(); chk("s3_b1", 8'h80, 3'd7, 8'h04, 1'b0);
    tick(); chk("s3_b2", 8'h80, 3'd7, 8'h04, 1'b0);
    req = 8'b0000_0010;
    tick(); chk("s3_dead2", 8'h00, 3'd0, 8'h01, 1'b0);
    req = 8'b1000_0010;
    tick(); chk("s3_c1", 8'h02, 3'd1, 8'h01, 1'b0);
    req = 8'd0;
    tick(); chk("s3_rel3", 8'h00, 3'd0, 8'h04, 1'b0);

    // expiry after four cycles
    req = 8'b0001_0000;
    tick(); chk("s4_h0", 8'h10, 3'd4, 8'h04, 1'b0);
    tick(); chk("s4_h1", 8'h10, 3'd4, 8'h04, 1'b0);
    tick(); chk("s4_h2", 8'h10, 3'd4, 8'h04, 1'b0);
    tick(); chk("s4_h3", 8'h10, 3'd4, 8'h04, 1'b0);
    tick(); chk("s4_tmo", 8'h00, 3'd0, 8'h20, 1'b1);
    tick(); chk("s4_regr", 8'h10, 3'd4, 8'h20, 1'b0);

    // drop coinciding with expiry: no timeout
    tick(); chk("s5_h1", 8'h10, 3'd4, 8'h20, 1'b0);
    tick(); chk("s5_h2", 8'h10, 3'd4, 8'h20, 1'b0);
    tick(); chk("s5_h3", 8'h10, 3'd4, 8'h20, 1'b0);
    req = 8'd0;
    tick(); chk("s5_drop", 8'h00, 3'd0, 8'h20, 1'b0);

    // async reset in the middle of a grant
    req = 8'b0000_0001;
    tick(); chk("s6_g0", 8'h01, 3'd0, 8'h20, 1'b0);
    tick(); chk("s6_g0b", 8'h01, 3'd0, 8'h20, 1'b0);
    #2 reset = 1'b0;
    #1 chk("s6_async", 8'h00, 3'd0, 8'h01, 1'b0);
    #1 reset = 1'b1;
    tick(); chk("s6_resume", 8'h01, 3'd0, 8'h01, 1'b0);
    req = 8'd0;
    tick(); chk("s6_rel", 8'h00, 3'd0, 8'h02, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
